// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared exception indices, reset vector and fetch FSM encodings
package if_fetch_unit_pkg;
  localparam int NUM_EX = 5;
  localparam int EXBITS_HI = NUM_EX - 1;
  localparam int EXBITS_LO = 0;
  localparam int EX_ADEL_BIT = 0;
  localparam int EX_RI_BIT = 1;
  localparam int EX_OV_BIT = 2;
  localparam int EX_SYS_BIT = 3;
  localparam int EX_BP_BIT = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  typedef logic [EXBITS_HI:EXBITS_LO] exbits_t;
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DATA = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: next fetch PC priority mux, flush over pending branch over pc+4
module if_next_pc (
  input  logic        flush,
  input  logic [31:0] ex_target,
  input  logic        br_pend,
  input  logic [31:0] br_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);
  assign next_pc = flush ? ex_target : br_pend ? br_target : pc + 32'd4;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage, single-outstanding fetch into IF/ID with delay-slot branches, flush, ADEL; FETCH_STALL_CNT_EN adds a DATA-wait counter
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = if_fetch_unit_pkg::RESET_PC,
  parameter int NUM_EX = if_fetch_unit_pkg::NUM_EX,
  parameter int EX_ADEL_BIT = if_fetch_unit_pkg::EX_ADEL_BIT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              inst_req,
  output logic [31:0]       inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  input  logic              id_allowin,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              ex_flush,
  input  logic [31:0]       ex_target,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic [NUM_EX-1:0] if_ex,
  output logic [31:0]       fetch_stall_cnt
);
  import if_fetch_unit_pkg::*;
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, br_tgt, br_tgt_n, br_sel, next_pc;
  logic br_pend, br_pend_n, cancel, cancel_n, cap_inst, cap_adel, misaligned;
  assign misaligned = pc[1:0] != 2'b00;
  assign br_sel = br_taken ? br_target : br_tgt;
  assign inst_req = ~reset & (state == S_REQ) & ~misaligned;
  assign inst_addr = pc;
  assign if_valid = ~reset & (state == S_HOLD);
  if_next_pc u_next_pc (
    .flush     (ex_flush),
    .ex_target (ex_target),
    .br_pend   (br_pend | br_taken),
    .br_target (br_sel),
    .pc        (pc),
    .next_pc   (next_pc)
  );
  always_comb begin
    state_n = state;
    pc_n = pc;
    cancel_n = cancel;
    br_pend_n = br_pend | br_taken;
    br_tgt_n = br_sel;
    cap_inst = 1'b0;
    cap_adel = 1'b0;
    case (state)
      S_REQ: begin
        cap_adel = misaligned;
        state_n = misaligned ? S_HOLD : inst_addr_ok ? S_DATA : S_REQ;
      end
      S_DATA: begin
        cap_inst = inst_data_ok & ~cancel;
        cancel_n = cancel & ~inst_data_ok;
        state_n = ~inst_data_ok ? S_DATA : cancel ? S_REQ : S_HOLD;
      end
      S_HOLD: if (id_allowin) begin
        state_n = S_REQ;
        pc_n = next_pc;
        br_pend_n = 1'b0;
      end
      default: state_n = S_REQ;
    endcase
    // a fetch already handed to the bus must still be drained, its word dropped via cancel
    if (ex_flush) begin
      pc_n = next_pc;
      br_pend_n = 1'b0;
      cap_inst = 1'b0;
      cap_adel = 1'b0;
      state_n = ((state == S_DATA) && !inst_data_ok) ||
                ((state == S_REQ) && inst_addr_ok && !misaligned) ? S_DATA : S_REQ;
      cancel_n = state_n == S_DATA;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
      pc <= RESET_PC;
      br_pend <= 1'b0;
      br_tgt <= '0;
      cancel <= 1'b0;
      if_pc <= '0;
      if_inst <= '0;
      if_ex <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      br_pend <= br_pend_n;
      br_tgt <= br_tgt_n;
      cancel <= cancel_n;
      if (cap_inst || cap_adel) begin
        if_pc <= pc;
        if_inst <= cap_inst ? inst_rdata : 32'd0;
        if_ex <= cap_adel ? NUM_EX'(1) << EX_ADEL_BIT : '0;
      end
    end
  end
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if ((state == S_DATA) && !inst_data_ok && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
  assign fetch_stall_cnt = stall_cnt;
`else
  assign fetch_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed plus randomized fetch bench against a PC-sequence reference model
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inst_req, inst_addr_ok, inst_data_ok, id_allowin, br_taken, ex_flush, if_valid;
  logic [31:0] inst_addr, inst_rdata, br_target, ex_target, if_pc, if_inst, fetch_stall_cnt;
  logic [4:0] if_ex;
  int checks = 0;
  int errors = 0;
  logic [31:0] key, m_pc, m_tgt;
  logic m_br;
  int m_stall;
  always #5 clk = ~clk;
  if_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok),
    .inst_data_ok    (inst_data_ok),
    .inst_rdata      (inst_rdata),
    .id_allowin      (id_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .ex_flush        (ex_flush),
    .ex_target       (ex_target),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_ex           (if_ex),
    .fetch_stall_cnt (fetch_stall_cnt)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ key;
  endfunction
  function automatic logic [31:0] exp_cnt();
`ifdef FETCH_STALL_CNT_EN
    return 32'(m_stall);
`else
    return 32'd0;
`endif
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_req", 32'(inst_req), 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_ex", 32'(if_ex), 0);
    chk("rst_cnt", fetch_stall_cnt, 0);
    reset = 1'b0;
    tick();
    m_pc = 32'hBFC0_0000;
    m_br = 1'b0;
    m_stall = 0;
    chk("boot_req", 32'(inst_req), 1);
    chk("boot_addr", inst_addr, 32'hBFC0_0000);
  endtask
  task automatic do_fetch(input int alat, input int dlat, input bit br, input logic [31:0] tgt, input int hold);
    for (int i = 0; i < alat; i++) begin
      chk("req_wait", 32'(inst_req), 1);
      chk("addr_wait", inst_addr, m_pc);
      tick();
    end
    chk("req", 32'(inst_req), 1);
    chk("addr", inst_addr, m_pc);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("req_drop", 32'(inst_req), 0);
    if (br) begin
      br_taken = 1'b1;
      br_target = tgt;
      tick();
      br_taken = 1'b0;
      m_br = 1'b1;
      m_tgt = tgt;
      m_stall++;
    end
    for (int i = 0; i < dlat; i++) begin
      chk("valid_wait", 32'(if_valid), 0);
      tick();
      m_stall++;
    end
    inst_rdata = mem(m_pc);
    inst_data_ok = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    inst_rdata = $urandom;
    chk("valid", 32'(if_valid), 1);
    chk("if_pc", if_pc, m_pc);
    chk("if_inst", if_inst, mem(m_pc));
    chk("if_ex", 32'(if_ex), 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(if_valid), 1);
      chk("hold_req", 32'(inst_req), 0);
      chk("hold_pc", if_pc, m_pc);
      chk("hold_inst", if_inst, mem(m_pc));
    end
    id_allowin = 1'b1;
    tick();
    id_allowin = 1'b0;
    chk("valid_fall", 32'(if_valid), 0);
    m_pc = m_br ? m_tgt : m_pc + 32'd4;
    m_br = 1'b0;
  endtask
  initial begin
    key = $urandom;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata = '0;
    id_allowin = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    ex_flush = 1'b0;
    ex_target = '0;
    do_reset();
    for (int i = 0; i < 3; i++) do_fetch(0, 0, 1'b0, 32'd0, 0);
    chk("seq_next", inst_addr, 32'hBFC0_000C);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    do_reset();
    do_fetch(0, 7, 1'b0, 32'd0, 0);
    chk("stall_cnt7", fetch_stall_cnt, exp_cnt());
    do_fetch(0, 0, 1'b1, 32'h8000_1000, 0);
    chk("br_redirect", inst_addr, 32'h8000_1000);
    do_fetch(1, 1, 1'b0, 32'd0, 5);
    chk("hold_advance", inst_addr, 32'h8000_1004);
    chk("fl_addr", inst_addr, m_pc);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    ex_flush = 1'b1;
    ex_target = 32'hBFC0_0380;
    br_taken = 1'b1;
    br_target = $urandom & 32'hFFFF_FFFC;
    tick();
    ex_flush = 1'b0;
    br_taken = 1'b0;
    m_stall++;
    chk("fl_valid0", 32'(if_valid), 0);
    tick();
    m_stall++;
    chk("fl_valid1", 32'(if_valid), 0);
    inst_rdata = mem(m_pc);
    inst_data_ok = 1'b1;
    tick();
    inst_data_ok = 1'b0;
    m_pc = 32'hBFC0_0380;
    m_br = 1'b0;
    chk("fl_drop", 32'(if_valid), 0);
    chk("fl_req", 32'(inst_req), 1);
    chk("fl_target", inst_addr, 32'hBFC0_0380);
    tick();
    chk("fl_drop2", 32'(if_valid), 0);
    do_fetch(0, 0, 1'b0, 32'd0, 0);
    chk("br_dropped", inst_addr, 32'hBFC0_0384);
    ex_flush = 1'b1;
    ex_target = 32'h8000_0002;
    tick();
    ex_flush = 1'b0;
    chk("adel_noreq0", 32'(inst_req), 0);
    chk("adel_valid0", 32'(if_valid), 0);
    tick();
    chk("adel_valid", 32'(if_valid), 1);
    chk("adel_ex", 32'(if_ex), 32'h1);
    chk("adel_inst", if_inst, 0);
    chk("adel_pc", if_pc, 32'h8000_0002);
    chk("adel_noreq1", 32'(inst_req), 0);
    ex_flush = 1'b1;
    ex_target = 32'hFFFF_FFFC;
    id_allowin = 1'b1;
    tick();
    ex_flush = 1'b0;
    id_allowin = 1'b0;
    m_pc = 32'hFFFF_FFFC;
    chk("fa_valid", 32'(if_valid), 0);
    chk("fa_req", 32'(inst_req), 1);
    chk("fa_addr", inst_addr, 32'hFFFF_FFFC);
    do_fetch(0, 1, 1'b0, 32'd0, 0);
    chk("wrap", inst_addr, 32'h0000_0000);
    for (int n = 0; n < 30; n++)
      do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
               $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 2)));
    chk("final_addr", inst_addr, m_pc);
    chk("final_cnt", fetch_stall_cnt, exp_cnt());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
